vga_plot_arbiter: RTL and testbench

- Shares the single VGA adapter plot port between up to NUM_REQ sprite engines; each engine is a control/datapath pair that draws 4x4 blocks as 16 pixel writes.
- Round-robin grant; one grant covers one burst of BURST_LEN plotted pixels, sized to one clear or draw pass.
- Pixels from the granted engine are registered onto the adapter port; a done pulse per engine tells its control FSM the pass is complete.

---
 rtl/vga_plot_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that hands the single VGA plot port to one sprite engine per burst of BURST_LEN pixels.
// Pixel path is registered (one cycle behind the strobe); define VGA_ARB_WATCHDOG_EN to revoke idle grants.
module vga_plot_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BURST_LEN   = 16,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_plot,
    input  logic [7*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_c,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [6:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_c,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 timeout
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [6:0]           x_q, x_d, y_q, y_d;
    logic [2:0]           c_q, c_d;
    logic                 plot_q, plot_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [PW-1:0]        own_q, own_d;
    logic [PW-1:0]        pick, nxt;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 found;
    logic                 accept;
    int                   scan;

`ifdef VGA_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    logic [WW-1:0]        wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        plot_d  = 1'b0;
        rr_d    = rr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        pick    = '0;
        scan    = 0;
`ifdef VGA_ARB_WATCHDOG_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        accept = req_plot[own_q] & req[own_q];
        nxt    = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);

        // Circular scan starting at rr_ptr; first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(rr_q) + k;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = PW'(scan);
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    own_d         = pick;
                    cnt_d         = '0;
                    state_d       = GRANT;
`ifdef VGA_ARB_WATCHDOG_EN
                    wdog_d        = '0;
`endif
                end
            end
            GRANT: begin
                if (accept) begin
                    plot_d = 1'b1;
                    x_d    = req_x[7*int'(own_q) +: 7];
                    y_d    = req_y[7*int'(own_q) +: 7];
                    c_d    = req_c[3*int'(own_q) +: 3];
                end
                if (!req[own_q]) begin
                    grant_d = '0;
                    rr_d    = nxt;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (accept) begin
`ifdef VGA_ARB_WATCHDOG_EN
                    wdog_d = '0;
`endif
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        done_d[own_q] = 1'b1;
                        grant_d       = '0;
                        rr_d          = nxt;
                        cnt_d         = '0;
                        state_d       = GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef VGA_ARB_WATCHDOG_EN
                else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    rr_d      = nxt;
                    cnt_d     = '0;
                    state_d   = GAP;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            rr_q    <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef VGA_ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES > 0);
    assign timeout     = 1'b0;
`endif

    assign grant    = grant_q;
    assign done     = done_q;
    assign vga_x    = x_q;
    assign vga_y    = y_q;
    assign vga_c    = c_q;
    assign vga_plot = plot_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: single burst, round-robin order, early release,
// ungranted-plot isolation, mid-burst reset, and (with VGA_ARB_WATCHDOG_EN) the idle revoke.
module tb_vga_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_plot;
    logic [27:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_c;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [6:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_c;
    logic        vga_plot;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    vga_plot_arbiter #(.NUM_REQ(4), .BURST_LEN(16), .WDOG_CYCLES(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_plot (req_plot),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_c    (req_c),
        .grant    (grant),
        .done     (done),
        .vga_x    (vga_x),
        .vga_y    (vga_y),
        .vga_c    (vga_c),
        .vga_plot (vga_plot),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int e, input int x, input int y, input int c);
        req_x[7*e +: 7] = 7'(x);
        req_y[7*e +: 7] = 7'(y);
        req_c[3*e +: 3] = 3'(c);
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_plot = '0;
        req_x    = '0;
        req_y    = '0;
        req_c    = '0;
        tick();
        tick();
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_done",  32'(done), 32'h0);
        check_val("rst_plot",  32'(vga_plot), 32'h0);
        check_val("rst_xyc",   {11'h0, vga_x, vga_y, vga_c}, 32'h0);
        check_val("rst_busy",  32'(busy), 32'h0);
        check_val("rst_tmo",   32'(timeout), 32'h0);
        reset = 1'b0;
        tick();

        // Single burst on engine 0 with a changing pixel stream.
        req      = 4'b0001;
        req_plot = 4'b0001;
        set_px(0, 10, 40, 0);
        tick();
        check_val("t1_grant", 32'(grant), 32'h1);
        check_val("t1_plot0", 32'(vga_plot), 32'h0);
        check_val("t1_busy",  32'(busy), 32'h1);
        for (int k = 0; k < 16; k++) begin
            set_px(0, 10 + k, 40 + k, k % 8);
            tick();
            check_val("t1_vplot", 32'(vga_plot), 32'h1);
            check_val("t1_vx",    32'(vga_x), 32'(10 + k));
            check_val("t1_vy",    32'(vga_y), 32'(40 + k));
            check_val("t1_vc",    32'(vga_c), 32'(k % 8));
            check_val("t1_done",  32'(done), (k == 15) ? 32'h1 : 32'h0);
            check_val("t1_gnt",   32'(grant), (k == 15) ? 32'h0 : 32'h1);
        end
        req      = '0;
        req_plot = '0;
        check_val("t1_gap_busy", 32'(busy), 32'h1);
        tick();
        check_val("t1_idle_done", 32'(done), 32'h0);
        check_val("t1_idle_plot", 32'(vga_plot), 32'h0);
        check_val("t1_idle_busy", 32'(busy), 32'h0);
        check_val("t1_hold_x",    32'(vga_x), 32'd25);

        // All four requesting; rr_ptr is 1 so order is 1,2,3,0,1.
        for (int e = 0; e < 4; e++) set_px(e, 50 + e, 60 + e, e + 1);
        req      = 4'b1111;
        req_plot = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            int own;
            own = (1 + b) % 4;
            tick();
            check_val("t2_grant", 32'(grant), 32'(1 << own));
            check_val("t2_done0", 32'(done), 32'h0);
            for (int k = 0; k < 16; k++) begin
                tick();
                check_val("t2_vplot", 32'(vga_plot), 32'h1);
                check_val("t2_vx",    32'(vga_x), 32'(50 + own));
                check_val("t2_vc",    32'(vga_c), 32'(own + 1));
                check_val("t2_done",  32'(done), (k == 15) ? 32'(1 << own) : 32'h0);
            end
            check_val("t2_gnt_off", 32'(grant), 32'h0);
            if (b == 4) req = '0;
            tick();
            check_val("t2_gap_gnt",  32'(grant), 32'h0);
            check_val("t2_gap_done", 32'(done), 32'h0);
            check_val("t2_gap_plot", 32'(vga_plot), 32'h0);
        end
        check_val("t2_idle_busy", 32'(busy), 32'h0);

        // Engine 2 drops its request after 5 pixels; engine 3 waits and goes next.
        req      = 4'b1100;
        req_plot = 4'b1100;
        tick();
        check_val("t3_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("t3_vx", 32'(vga_x), 32'd52);
        end
        req = 4'b1000;
        tick();
        check_val("t3_rel_gnt",  32'(grant), 32'h0);
        check_val("t3_rel_done", 32'(done), 32'h0);
        check_val("t3_rel_plot", 32'(vga_plot), 32'h0);
        check_val("t3_rel_x",    32'(vga_x), 32'd52);
        tick();
        check_val("t3_gap_gnt", 32'(grant), 32'h0);
        tick();
        check_val("t3_next", 32'(grant), 32'h8);
        req = '0;
        tick();
        check_val("t3_rel3_gnt", 32'(grant), 32'h0);
        check_val("t3_rel3_done", 32'(done), 32'h0);
        tick();

        // Engine 1 owns the port while engine 0 strobes x=99; rr_ptr is 0 here.
        set_px(0, 99, 9, 7);
        req      = 4'b0010;
        req_plot = 4'b0011;
        tick();
        check_val("t4_grant", 32'(grant), 32'h2);
        req = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_val("t4_vx",   32'(vga_x), 32'd51);
            check_val("t4_vy",   32'(vga_y), 32'd61);
            check_val("t4_done", 32'(done), (k == 15) ? 32'h2 : 32'h0);
        end
        tick();
        check_val("t4_gap_gnt", 32'(grant), 32'h0);
        tick();
        check_val("t4_wrap_gnt", 32'(grant), 32'h1);

        // Mid-burst reset on engine 0 after its 8th pixel.
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("t5_vx", 32'(vga_x), 32'd99);
        end
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        check_val("t5_rst_gnt",  32'(grant), 32'h0);
        check_val("t5_rst_done", 32'(done), 32'h0);
        check_val("t5_rst_plot", 32'(vga_plot), 32'h0);
        check_val("t5_rst_xyc",  {11'h0, vga_x, vga_y, vga_c}, 32'h0);
        check_val("t5_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();
        check_val("t5_restart", 32'(grant), 32'h1);
        req      = '0;
        req_plot = '0;
        tick();
        tick();

`ifdef VGA_ARB_WATCHDOG_EN
        // Engine 0 granted but never plots; engine 1 waits behind it. rr_ptr is 1 after the release above.
        req = 4'b0001;
        tick();
        check_val("t6_grant", 32'(grant), 32'h1);
        req = 4'b0011;
        for (int k = 0; k < 63; k++) begin
            tick();
            check_val("t6_hold", 32'(grant), 32'h1);
            check_val("t6_tmo0", 32'(timeout), 32'h0);
        end
        tick();
        check_val("t6_tmo",      32'(timeout), 32'h1);
        check_val("t6_tmo_gnt",  32'(grant), 32'h0);
        check_val("t6_tmo_done", 32'(done), 32'h0);
        tick();
        check_val("t6_tmo_pulse", 32'(timeout), 32'h0);
        tick();
        check_val("t6_next", 32'(grant), 32'h2);
        req = '0;
        tick();
`else
        check_val("tmo_tied", 32'(timeout), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
